// File: rtl/ibex_mem_arb_pkg.sv
// Shared types for the instr/data memory-port arbiter.
// Source IDs travel through the response FIFO as mem_src_e.
package ibex_mem_arb_pkg;

  typedef enum logic {
    MemSrcInstr = 1'b0,
    MemSrcData  = 1'b1
  } mem_src_e;

  typedef enum logic {
    ARB_IDLE,
    ARB_LOCKED
  } arb_state_e;

  localparam logic [3:0] BeWord = 4'hF;

  function automatic mem_src_e other_src(mem_src_e s);
    return (s == MemSrcInstr) ? MemSrcData : MemSrcInstr;
  endfunction

endpackage

// File: rtl/ibex_mem_arbiter_if.sv
// req/gnt/rvalid memory bus bundle.
// master drives the request, slave answers with grant and response.
interface ibex_mem_arbiter_if;
  logic        req;
  logic        we;
  logic [3:0]  be;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;

  modport master (
    output req, we, be, addr, wdata,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, we, be, addr, wdata,
    output gnt, rvalid, rdata, err
  );
endinterface

// File: rtl/ibex_mem_arb_id_fifo.sv
// In-order FIFO of source IDs for granted, unanswered transactions.
// Wrap-around pointers; push is accepted when full only alongside a pop.
module ibex_mem_arb_id_fifo
  import ibex_mem_arb_pkg::*;
#(
  parameter int unsigned Depth = 2,
  localparam int unsigned CntW = $clog2(Depth + 1),
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            push_i,
  input  mem_src_e        src_i,
  input  logic            pop_i,
  output mem_src_e        head_o,
  output logic [CntW-1:0] count_o,
  output logic            full_o,
  output logic            empty_o
);

  mem_src_e        q [Depth];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic            do_push, do_pop;

  function automatic logic [PtrW-1:0] inc(logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = q[rd_ptr_q];
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= inc(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= inc(rd_ptr_q);
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) q[wr_ptr_q] <= src_i;
  end

endmodule

// File: rtl/ibex_mem_arbiter.sv
// Shares one downstream memory port between instr fetch and LSU.
// Winner is locked until granted; responses return in grant order.
module ibex_mem_arbiter
  import ibex_mem_arb_pkg::*;
#(
  parameter int unsigned MaxOutstanding = 2,
  parameter bit          DataPriority   = 1'b0,
  localparam int unsigned CntW = $clog2(MaxOutstanding + 1)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  ibex_mem_arbiter_if.slave  instr,
  ibex_mem_arbiter_if.slave  data,
  ibex_mem_arbiter_if.master mem,
  output logic [CntW-1:0]    outstanding_o,
  output logic               unexpected_rvalid_o
);

  arb_state_e state_q, state_d;
  mem_src_e   lock_src_q, last_src_q;
  mem_src_e   win_src, head_src;
  logic       win_req, full, empty;
  logic       hs, rsp;

  always_comb begin
    win_src = lock_src_q;
    if (state_q == ARB_IDLE) begin
      unique case (1'b1)
        instr.req && data.req:
          win_src = DataPriority ? MemSrcData
                                 : other_src(last_src_q);
        data.req && !instr.req:
          win_src = MemSrcData;
        default:
          win_src = MemSrcInstr;
      endcase
    end
  end

  assign win_req = (win_src == MemSrcData) ? data.req : instr.req;
  // Full check on the registered count keeps rvalid off the req path.
  assign mem.req = win_req & ~full;
  assign hs      = mem.req & mem.gnt;

  always_comb begin
    mem.we    = 1'b0;
    mem.be    = '0;
    mem.addr  = '0;
    mem.wdata = '0;
    if (win_req) begin
      if (win_src == MemSrcData) begin
        mem.we    = data.we;
        mem.be    = data.be;
        mem.addr  = data.addr;
        mem.wdata = data.wdata;
      end else begin
        mem.be   = BeWord;
        mem.addr = instr.addr;
      end
    end
  end

  assign instr.gnt = hs & (win_src == MemSrcInstr);
  assign data.gnt  = hs & (win_src == MemSrcData);

  assign rsp          = mem.rvalid & ~empty;
  assign instr.rvalid = rsp & (head_src == MemSrcInstr);
  assign data.rvalid  = rsp & (head_src == MemSrcData);
  assign instr.rdata  = mem.rdata;
  assign instr.err    = mem.err;
  assign data.rdata   = mem.rdata;
  assign data.err     = mem.err;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ARB_IDLE:   if (mem.req && !mem.gnt) state_d = ARB_LOCKED;
      ARB_LOCKED: if (!mem.req || mem.gnt) state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q             <= ARB_IDLE;
      lock_src_q          <= MemSrcInstr;
      last_src_q          <= MemSrcData;
      unexpected_rvalid_o <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ARB_IDLE) lock_src_q <= win_src;
      if (hs) last_src_q <= win_src;
      if (mem.rvalid && empty) unexpected_rvalid_o <= 1'b1;
    end
  end

  ibex_mem_arb_id_fifo #(
    .Depth (MaxOutstanding)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (hs),
    .src_i   (win_src),
    .pop_i   (rsp),
    .head_o  (head_src),
    .count_o (outstanding_o),
    .full_o  (full),
    .empty_o (empty)
  );

endmodule

// File: tb/tb_ibex_mem_arbiter.sv
// Bench for ibex_mem_arbiter: round-robin (dut0) and data-priority (dut1)
// instances checked every cycle against a queue-based model.
module tb_ibex_mem_arbiter;
  import ibex_mem_arb_pkg::*;

  localparam int MaxOut = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  bit checking = 1'b0;

  logic        ireq [2], dreq [2], dwe [2];
  logic        mgnt [2], mrv [2], merr [2];
  logic [3:0]  dbe [2];
  logic [31:0] iaddr [2], daddr [2], dwd [2], mrd [2];

  logic [1:0]  o_req, o_we, o_igt, o_dgt, o_irv, o_drv;
  logic [1:0]  o_ierr, o_derr, o_unexp;
  logic [3:0]  o_be [2];
  logic [31:0] o_addr [2], o_wd [2], o_ird [2], o_drd [2];
  logic [1:0]  o_cnt [2];

  for (genvar k = 0; k < 2; k++) begin : g_dut
    ibex_mem_arbiter_if ibus ();
    ibex_mem_arbiter_if dbus ();
    ibex_mem_arbiter_if mbus ();

    assign ibus.req   = ireq[k];
    assign ibus.we    = 1'b0;
    assign ibus.be    = 4'h0;
    assign ibus.addr  = iaddr[k];
    assign ibus.wdata = '0;
    assign dbus.req   = dreq[k];
    assign dbus.we    = dwe[k];
    assign dbus.be    = dbe[k];
    assign dbus.addr  = daddr[k];
    assign dbus.wdata = dwd[k];
    assign mbus.gnt    = mgnt[k];
    assign mbus.rvalid = mrv[k];
    assign mbus.rdata  = mrd[k];
    assign mbus.err    = merr[k];

    assign o_req[k]  = mbus.req;
    assign o_we[k]   = mbus.we;
    assign o_be[k]   = mbus.be;
    assign o_addr[k] = mbus.addr;
    assign o_wd[k]   = mbus.wdata;
    assign o_igt[k]  = ibus.gnt;
    assign o_dgt[k]  = dbus.gnt;
    assign o_irv[k]  = ibus.rvalid;
    assign o_drv[k]  = dbus.rvalid;
    assign o_ird[k]  = ibus.rdata;
    assign o_drd[k]  = dbus.rdata;
    assign o_ierr[k] = ibus.err;
    assign o_derr[k] = dbus.err;

    ibex_mem_arbiter #(
      .MaxOutstanding (MaxOut),
      .DataPriority   (k == 1)
    ) u_dut (
      .clk_i               (clk),
      .rst_i               (rst),
      .instr               (ibus),
      .data                (dbus),
      .mem                 (mbus),
      .outstanding_o       (o_cnt[k]),
      .unexpected_rvalid_o (o_unexp[k])
    );
  end

  // Model: in-flight source queue (0=instr, 1=data), last granted
  // source, source held across a stalled grant (-1 = none).
  int m_q [2][MaxOut];
  int m_n [2];
  int m_last [2];
  int m_held [2];
  bit m_unexp [2];

  function automatic void chk(int k, string nm,
                              logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL dut%0d %s: got %h want %h @%0t",
               k, nm, act, exp, $time);
    end
  endfunction

  function automatic void model_reset(int k);
    m_n[k]     = 0;
    m_last[k]  = 1;
    m_held[k]  = -1;
    m_unexp[k] = 1'b0;
  endfunction

  function automatic int winner(int k);
    if (m_held[k] >= 0) return m_held[k];
    if (ireq[k] && dreq[k]) return (k == 1) ? 1 : 1 - m_last[k];
    if (dreq[k]) return 1;
    if (ireq[k]) return 0;
    return -1;
  endfunction

  function automatic void check_cycle(int k);
    int w, head;
    bit wr, er, gv;
    logic [31:0] ea, ewd;
    logic [3:0] ebe;
    logic ewe;
    w   = winner(k);
    wr  = (w == 0) ? ireq[k] : (w == 1) ? dreq[k] : 1'b0;
    er  = wr && (m_n[k] < MaxOut);
    ea  = '0; ewd = '0; ebe = '0; ewe = 1'b0;
    if (wr && w == 1) begin
      ea = daddr[k]; ewd = dwd[k]; ebe = dbe[k]; ewe = dwe[k];
    end else if (wr) begin
      ea = iaddr[k]; ebe = 4'hF;
    end
    chk(k, "mem_req", o_req[k], er);
    chk(k, "mem_addr", o_addr[k], ea);
    chk(k, "mem_we", o_we[k], ewe);
    chk(k, "mem_be", o_be[k], ebe);
    chk(k, "mem_wdata", o_wd[k], ewd);
    gv = er && mgnt[k];
    chk(k, "instr_gnt", o_igt[k], gv && w == 0);
    chk(k, "data_gnt", o_dgt[k], gv && w == 1);
    head = (mrv[k] && m_n[k] > 0) ? m_q[k][0] : -1;
    chk(k, "instr_rvalid", o_irv[k], head == 0);
    chk(k, "data_rvalid", o_drv[k], head == 1);
    if (head == 0) begin
      chk(k, "instr_rdata", o_ird[k], mrd[k]);
      chk(k, "instr_err", o_ierr[k], merr[k]);
    end
    if (head == 1) begin
      chk(k, "data_rdata", o_drd[k], mrd[k]);
      chk(k, "data_err", o_derr[k], merr[k]);
    end
    chk(k, "outstanding", o_cnt[k], m_n[k]);
    chk(k, "unexpected", o_unexp[k], m_unexp[k]);
    if (mrv[k]) begin
      if (m_n[k] > 0) begin
        for (int j = 0; j < MaxOut - 1; j++) m_q[k][j] = m_q[k][j+1];
        m_n[k]--;
      end else begin
        m_unexp[k] = 1'b1;
      end
    end
    if (gv) begin
      m_q[k][m_n[k]] = w;
      m_n[k]++;
      m_last[k] = w;
    end
    m_held[k] = (er && !mgnt[k]) ? w : -1;
  endfunction

  always @(posedge rst) begin
    for (int k = 0; k < 2; k++) model_reset(k);
  end

  always @(negedge clk) begin
    if (checking && !rst)
      for (int k = 0; k < 2; k++) check_cycle(k);
  end

  task automatic idle_all();
    for (int k = 0; k < 2; k++) begin
      ireq[k] = 0; dreq[k] = 0; dwe[k] = 0; dbe[k] = '0;
      iaddr[k] = '0; daddr[k] = '0; dwd[k] = '0;
      mgnt[k] = 0; mrv[k] = 0; merr[k] = 0; mrd[k] = '0;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
    #1;
  endtask

  task automatic drain();
    cyc();
    idle_all();
    for (int k = 0; k < 2; k++) mrv[k] = 1;
    smp();
  endtask

  initial begin
    idle_all();
    for (int k = 0; k < 2; k++) model_reset(k);
    #1 rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    checking = 1'b1;
    smp();
    for (int k = 0; k < 2; k++) begin
      chk(k, "rst_cnt", o_cnt[k], 0);
      chk(k, "rst_unexp", o_unexp[k], 0);
      chk(k, "rst_req", o_req[k], 0);
      chk(k, "rst_addr", o_addr[k], 0);
    end

    // Instr-only stream with 1-cycle response latency
    for (int i = 0; i < 6; i++) begin
      cyc();
      for (int k = 0; k < 2; k++) begin
        ireq[k] = 1; iaddr[k] = 32'h1000 + 4 * i;
        mgnt[k] = 1; mrv[k] = (i > 0); mrd[k] = 32'h1111_0000 + i;
      end
      smp();
      for (int k = 0; k < 2; k++) begin
        chk(k, "io_be", o_be[k], 4'hF);
        chk(k, "io_we", o_we[k], 0);
        chk(k, "io_gnt", o_igt[k], 1);
        chk(k, "io_irv", o_irv[k], i > 0);
        chk(k, "io_drv", o_drv[k], 0);
        if (i > 0) chk(k, "io_rdata", o_ird[k], 32'h1111_0000 + i);
      end
    end

    // Both requesting continuously
    for (int i = 0; i < 8; i++) begin
      cyc();
      for (int k = 0; k < 2; k++) begin
        ireq[k] = 1; dreq[k] = 1; dwe[k] = 0; dbe[k] = 4'hF;
        daddr[k] = 32'h2000 + 4 * i; iaddr[k] = 32'h1800 + 4 * i;
        mgnt[k] = 1; mrv[k] = 1; mrd[k] = 32'h2222_0000 + i;
      end
      smp();
      chk(0, "rr_dgnt", o_dgt[0], i % 2 == 0);
      chk(0, "rr_ignt", o_igt[0], i % 2 == 1);
      chk(0, "rr_drv", o_drv[0], i > 0 && (i - 1) % 2 == 0);
      chk(0, "rr_irv", o_irv[0], i == 0 || (i - 1) % 2 == 1);
      chk(1, "dp_dgnt", o_dgt[1], 1);
      chk(1, "dp_ignt", o_igt[1], 0);
      chk(1, "dp_drv", o_drv[1], i > 0);
      chk(1, "dp_irv", o_irv[1], i == 0);
    end

    // Data-only handshake alongside a pop, then empty the FIFO
    cyc();
    idle_all();
    for (int k = 0; k < 2; k++) begin
      dreq[k] = 1; mgnt[k] = 1; mrv[k] = 1;
    end
    smp();
    for (int k = 0; k < 2; k++) chk(k, "pp_cnt", o_cnt[k], 1);
    drain();

    // Stalled data store; instr arrives during the stall
    for (int i = 0; i < 5; i++) begin
      cyc();
      idle_all();
      for (int k = 0; k < 2; k++) begin
        dreq[k] = (i < 4); dwe[k] = 1; daddr[k] = 32'h100;
        dbe[k] = 4'h3; dwd[k] = 32'hA5A5;
        ireq[k] = (i >= 1); iaddr[k] = 32'h3000;
        mgnt[k] = (i >= 3); mrv[k] = (i == 4); mrd[k] = 32'h3333_0000;
      end
      smp();
      for (int k = 0; k < 2; k++) begin
        if (i <= 3) begin
          chk(k, "st_req", o_req[k], 1);
          chk(k, "st_addr", o_addr[k], 32'h100);
          chk(k, "st_be", o_be[k], 4'h3);
          chk(k, "st_wdata", o_wd[k], 32'hA5A5);
          chk(k, "st_igt", o_igt[k], 0);
          chk(k, "st_dgt", o_dgt[k], i == 3);
        end else begin
          chk(k, "st_igt_after", o_igt[k], 1);
          chk(k, "st_drv", o_drv[k], 1);
        end
      end
    end
    drain();

    // Outstanding limit
    for (int i = 0; i < 6; i++) begin
      cyc();
      idle_all();
      for (int k = 0; k < 2; k++) begin
        ireq[k] = (i < 5); iaddr[k] = 32'h4000 + 4 * i;
        mgnt[k] = 1; mrv[k] = (i == 3 || i == 4);
        mrd[k] = 32'h4444_0000 + i;
      end
      smp();
      for (int k = 0; k < 2; k++) begin
        unique case (i)
          0: chk(k, "fl_gnt0", o_igt[k], 1);
          1: chk(k, "fl_cnt1", o_cnt[k], 1);
          2: begin
            chk(k, "fl_blk_req", o_req[k], 0);
            chk(k, "fl_blk_cnt", o_cnt[k], 2);
          end
          3: begin
            chk(k, "fl_pop_req", o_req[k], 0);
            chk(k, "fl_pop_irv", o_irv[k], 1);
          end
          4: begin
            chk(k, "fl_reopen_gnt", o_igt[k], 1);
            chk(k, "fl_reopen_cnt", o_cnt[k], 1);
          end
          default: chk(k, "fl_pushpop_cnt", o_cnt[k], 1);
        endcase
      end
    end
    drain();

    // rvalid with nothing outstanding
    cyc();
    idle_all();
    for (int k = 0; k < 2; k++) mrv[k] = 1;
    smp();
    for (int k = 0; k < 2; k++) begin
      chk(k, "ux_irv", o_irv[k], 0);
      chk(k, "ux_drv", o_drv[k], 0);
    end
    for (int n = 0; n < 2; n++) begin
      cyc();
      idle_all();
      smp();
      for (int k = 0; k < 2; k++) chk(k, "ux_sticky", o_unexp[k], 1);
    end

    // Asynchronous reset with transactions in flight
    for (int i = 0; i < 2; i++) begin
      cyc();
      idle_all();
      for (int k = 0; k < 2; k++) begin
        ireq[k] = 1; mgnt[k] = 1;
      end
    end
    cyc();
    idle_all();
    #1 rst = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk(k, "ar_cnt", o_cnt[k], 0);
      chk(k, "ar_unexp", o_unexp[k], 0);
      chk(k, "ar_req", o_req[k], 0);
    end
    cyc();
    rst = 1'b0;
    for (int k = 0; k < 2; k++) mrv[k] = 1;
    smp();
    for (int k = 0; k < 2; k++) chk(k, "ar_late_irv", o_irv[k], 0);
    cyc();
    idle_all();
    smp();
    for (int k = 0; k < 2; k++) chk(k, "ar_late_unexp", o_unexp[k], 1);

    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      cyc();
      for (int k = 0; k < 2; k++) begin
        ireq[k]  = ($urandom_range(0, 3) != 0);
        dreq[k]  = ($urandom_range(0, 3) != 0);
        dwe[k]   = 1'($urandom);
        dbe[k]   = 4'($urandom);
        iaddr[k] = $urandom;
        daddr[k] = $urandom;
        dwd[k]   = $urandom;
        mgnt[k]  = ($urandom_range(0, 9) < 7);
        mrv[k]   = (m_n[k] > 0) ? ($urandom_range(0, 9) < 6)
                                : ($urandom_range(0, 199) == 0);
        mrd[k]   = $urandom;
        merr[k]  = 1'($urandom);
      end
    end
    smp();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
